// File: rtl/sonic_vc_rx_width_down_adapter_pkg.sv
// sonic_vc_rx_pkg: packing constants, FSM states and beat formats for the RX width-down adapter.
package sonic_vc_rx_pkg;
    localparam int DATA_LSB  = 0;
    localparam int DATA_MSB  = 127;
    localparam int EMPTY_LSB = 128;
    localparam int ERR_BIT   = 130;
    localparam int SOP_BIT   = 131;
    localparam int EOP_BIT   = 132;
    localparam int IN_BEAT_W = 133;
    localparam int OUT_W     = 64;

    typedef enum logic [1:0] {EMPTY, HI, LO} state_e;

    typedef struct packed {
        logic                       eop;
        logic                       sop;
        logic                       err;
        logic [1:0]                 empty_w;
        logic [DATA_MSB:DATA_LSB]   data;
    } in_beat_t;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             sop;
        logic             eop;
        logic             err;
        logic             empty;
    } out_beat_t;
endpackage

// File: rtl/sonic_vc_rx_width_down_adapter_if.sv
// sonic_vc_rx_width_down_adapter_if: 133-bit packed input stream, 64-bit output stream and stats.
interface sonic_vc_rx_width_down_adapter_if #(
    parameter int IN_DATA_WIDTH  = 128,
    parameter int OUT_DATA_WIDTH = 64,
    parameter int STATS_WIDTH    = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [IN_DATA_WIDTH+4:0]  in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [OUT_DATA_WIDTH-1:0] out_data;
    logic                      out_sop;
    logic                      out_eop;
    logic                      out_err;
    logic                      out_empty;
    logic [STATS_WIDTH-1:0]    stat_pkts;
    logic [STATS_WIDTH-1:0]    stat_errs;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_eop, out_err, out_empty, stat_pkts, stat_errs
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_eop, out_err, out_empty, stat_pkts, stat_errs
    );
endinterface

// File: rtl/sonic_vc_rx_width_down_adapter_stats.sv
// sonic_vc_rx_adapter_stats: wrapping counters of emitted packets and errored packets.
module sonic_vc_rx_adapter_stats #(
    parameter int STATS_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pkt_done,
    input  logic                   pkt_err,
    output logic [STATS_WIDTH-1:0] stat_pkts,
    output logic [STATS_WIDTH-1:0] stat_errs
);
    logic [STATS_WIDTH-1:0] pkts_q, pkts_d, errs_q, errs_d;

    always_comb begin
        pkts_d = pkt_done ? pkts_q + 1'b1 : pkts_q;
        errs_d = pkt_done && pkt_err ? errs_q + 1'b1 : errs_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkts_q <= '0;
            errs_q <= '0;
        end else begin
            pkts_q <= pkts_d;
            errs_q <= errs_d;
        end
    end

    assign stat_pkts = pkts_q;
    assign stat_errs = errs_q;
endmodule

// File: rtl/sonic_vc_rx_width_down_adapter.sv
// sonic_vc_rx_width_down_adapter: splits 128-bit packed beats into 64-bit beats, MS half first.
// Define SONIC_VC_RX_ADAPTER_STATS_EN to enable the packet/error counters.
module sonic_vc_rx_width_down_adapter
    import sonic_vc_rx_pkg::*;
#(
    parameter int IN_DATA_WIDTH  = 128,
    parameter int OUT_DATA_WIDTH = 64,
    parameter int STATS_WIDTH    = 32
) (
    input logic clk,
    input logic reset,
    sonic_vc_rx_width_down_adapter_if.slave bus
);
    state_e    state_q, state_d;
    out_beat_t out_q, out_d, lo_q, lo_d;
    logic      two_q, two_d, sticky_q, sticky_d;
    in_beat_t  b;
    logic [1:0] ew;
    logic      two, pkt_err, last_shown, in_rdy, acc;

    // The eop beat's error is folded in at input acceptance, so sticky only spans non-eop beats.
    always_comb begin
        b          = in_beat_t'(bus.in_data);
        ew         = b.eop ? b.empty_w : 2'd0;
        two        = !ew[1];
        pkt_err    = sticky_q | b.err;
        last_shown = state_q == LO || (state_q == HI && !two_q);
        in_rdy     = state_q == EMPTY || (bus.out_ready && last_shown);
        acc        = bus.in_valid && in_rdy;
        state_d    = state_q;
        out_d      = out_q;
        lo_d       = lo_q;
        two_d      = two_q;
        sticky_d   = sticky_q;
        if (state_q == HI && two_q && bus.out_ready) begin
            state_d = LO;
            out_d   = lo_q;
        end else if (bus.out_ready && last_shown) begin
            state_d = EMPTY;
        end
        if (acc) begin
            state_d  = HI;
            two_d    = two;
            sticky_d = !b.eop && pkt_err;
            out_d    = '{data: b.data[IN_DATA_WIDTH-1:OUT_DATA_WIDTH], sop: b.sop,
                         eop: b.eop && !two, err: b.eop && !two && pkt_err, empty: !two && ew[0]};
            lo_d     = '{data: b.data[OUT_DATA_WIDTH-1:0], sop: 1'b0,
                         eop: b.eop, err: b.eop && pkt_err, empty: ew[0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= EMPTY;
            out_q    <= '0;
            lo_q     <= '0;
            two_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            lo_q     <= lo_d;
            two_q    <= two_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = state_q != EMPTY;
    assign bus.out_data  = out_q.data;
    assign bus.out_sop   = out_q.sop;
    assign bus.out_eop   = out_q.eop;
    assign bus.out_err   = out_q.err;
    assign bus.out_empty = out_q.empty;

`ifdef SONIC_VC_RX_ADAPTER_STATS_EN
    logic [STATS_WIDTH-1:0] pkts, errs;

    sonic_vc_rx_adapter_stats #(.STATS_WIDTH(STATS_WIDTH)) u_stats (
        .clk      (clk),
        .reset    (reset),
        .pkt_done (state_q != EMPTY && bus.out_ready && out_q.eop),
        .pkt_err  (out_q.err),
        .stat_pkts(pkts),
        .stat_errs(errs)
    );

    assign bus.stat_pkts = pkts;
    assign bus.stat_errs = errs;
`else
    assign bus.stat_pkts = {STATS_WIDTH{1'b0}};
    assign bus.stat_errs = {STATS_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_sonic_vc_rx_width_down_adapter.sv
// tb_sonic_vc_rx_width_down_adapter: directed and randomised checks of the 128->64 RX adapter.
module tb_sonic_vc_rx_width_down_adapter;
    typedef struct packed {
        logic [63:0] d;
        logic        sop;
        logic        eop;
        logic        err;
        logic        empty;
    } ob_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rnd_en = 1'b0;
    int   passed = 0;
    int   total = 0;
    ob_t  q[$];
    ob_t  exp_q[$];

    always #5 clk = ~clk;

    sonic_vc_rx_width_down_adapter_if bus ();

    sonic_vc_rx_width_down_adapter dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always @(negedge clk)
        if (!reset && bus.out_valid && bus.out_ready)
            q.push_back('{d: bus.out_data, sop: bus.out_sop, eop: bus.out_eop, err: bus.out_err, empty: bus.out_empty});

    always @(posedge clk)
        if (rnd_en) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end

    function automatic logic [132:0] mk(input logic eop, input logic sop, input logic err,
                                        input logic [1:0] ew, input logic [127:0] d);
        return {eop, sop, err, ew, d};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [132:0] d);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles, want 1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        idle(3);
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
        total++; if (bus.out_data !== 64'd0) $display("FAIL reset_out_data: got %h want 0", bus.out_data); else passed++;
        total++; if ({bus.out_sop, bus.out_eop, bus.out_err, bus.out_empty} !== 4'b0)
            $display("FAIL reset_flags: got %b want 0000", {bus.out_sop, bus.out_eop, bus.out_err, bus.out_empty}); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else passed++;
        total++; if ({bus.stat_pkts, bus.stat_errs} !== 64'd0)
            $display("FAIL reset_stats: got %h/%h want 0/0", bus.stat_pkts, bus.stat_errs); else passed++;
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_three_beat();
        logic [63:0] hi[3] = '{64'h1111_1111_2222_2222, 64'h5555_5555_6666_6666, 64'h9999_9999_AAAA_AAAA};
        logic [63:0] lo[3] = '{64'h3333_3333_4444_4444, 64'h7777_7777_8888_8888, 64'hBBBB_BBBB_CCCC_CCCC};
        q.delete();
        bus.out_ready = 1'b1;
        send(mk(1'b0, 1'b1, 1'b0, 2'd3, {hi[0], lo[0]}));
        send(mk(1'b0, 1'b0, 1'b0, 2'd2, {hi[1], lo[1]}));
        send(mk(1'b1, 1'b0, 1'b0, 2'd0, {hi[2], lo[2]}));
        idle(5);
        total++; if (q.size() != 6) $display("FAIL three_count: got %0d want 6", q.size()); else passed++;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (q[i] !== '{d: (i % 2) ? lo[i/2] : hi[i/2], sop: i == 0, eop: i == 5, err: 1'b0, empty: 1'b0})
                $display("FAIL three_beat%0d: got %h want data %h sop %0d eop %0d", i, q[i],
                         (i % 2) ? lo[i/2] : hi[i/2], i == 0, i == 5);
            else passed++;
        end
    endtask

    task automatic test_single_beat();
        q.delete();
        bus.out_ready = 1'b1;
        send(mk(1'b1, 1'b1, 1'b0, 2'd3, 128'hDEAD_BEEF_0BAD_F00D_0123_4567_89AB_CDEF));
        total++; if (bus.out_valid !== 1'b1) $display("FAIL single_latency: out_valid got %b want 1", bus.out_valid); else passed++;
        total++; if (bus.out_data !== 64'hDEAD_BEEF_0BAD_F00D) $display("FAIL single_data: got %h want deadbeef0badf00d", bus.out_data); else passed++;
        total++; if ({bus.out_sop, bus.out_eop, bus.out_empty} !== 3'b111)
            $display("FAIL single_flags: got %b want 111", {bus.out_sop, bus.out_eop, bus.out_empty}); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL single_in_ready: got %b want 1", bus.in_ready); else passed++;
        idle(4);
        total++; if (q.size() != 1) $display("FAIL single_count: got %0d want 1", q.size()); else passed++;
    endtask

    task automatic test_error();
        do_reset();
        q.delete();
        bus.out_ready = 1'b1;
        send(mk(1'b0, 1'b1, 1'b0, 2'd0, {4{32'hA0A0_0001}}));
        send(mk(1'b0, 1'b0, 1'b1, 2'd0, {4{32'hA0A0_0002}}));
        send(mk(1'b1, 1'b0, 1'b0, 2'd0, {4{32'hA0A0_0003}}));
        send(mk(1'b1, 1'b1, 1'b0, 2'd1, {4{32'hB0B0_0001}}));
        idle(5);
        total++; if (q.size() != 8) $display("FAIL err_count: got %0d want 8", q.size()); else passed++;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (q[i].err !== (i == 5)) $display("FAIL err_beat%0d: got %b want %0d", i, q[i].err, i == 5); else passed++;
        end
        total++; if ({q[7].eop, q[7].empty} !== 2'b11) $display("FAIL err_pkt2_tail: eop/empty got %b want 11", {q[7].eop, q[7].empty}); else passed++;
`ifdef SONIC_VC_RX_ADAPTER_STATS_EN
        total++; if (bus.stat_pkts !== 32'd2) $display("FAIL stat_pkts: got %0d want 2", bus.stat_pkts); else passed++;
        total++; if (bus.stat_errs !== 32'd1) $display("FAIL stat_errs: got %0d want 1", bus.stat_errs); else passed++;
`else
        total++; if ({bus.stat_pkts, bus.stat_errs} !== 64'd0)
            $display("FAIL stat_disabled: got %h/%h want 0/0", bus.stat_pkts, bus.stat_errs); else passed++;
`endif
    endtask

    task automatic test_stall();
        logic [127:0] a = 128'hC001_0001_C001_0002_C001_0003_C001_0004;
        logic [127:0] b = 128'hD002_0001_D002_0002_D002_0003_D002_0004;
        q.delete();
        bus.out_ready = 1'b0;
        send(mk(1'b1, 1'b1, 1'b0, 2'd0, a));
        bus.in_valid = 1'b1;
        bus.in_data  = mk(1'b1, 1'b1, 1'b0, 2'd0, b);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            total++; if ({bus.out_valid, bus.out_sop, bus.in_ready} !== 3'b110)
                $display("FAIL stall%0d_ctl: valid/sop/in_ready got %b want 110", i, {bus.out_valid, bus.out_sop, bus.in_ready}); else passed++;
            total++; if (bus.out_data !== a[127:64]) $display("FAIL stall%0d_data: got %h want %h", i, bus.out_data, a[127:64]); else passed++;
        end
        bus.out_ready = 1'b1;
        send(mk(1'b1, 1'b1, 1'b0, 2'd0, b));
        idle(5);
        total++; if (q.size() != 4) $display("FAIL stall_count: got %0d want 4", q.size()); else passed++;
        total++; if ({q[0].d, q[1].d, q[2].d, q[3].d} !== {a, b})
            $display("FAIL stall_order: got %h %h %h %h want %h %h", q[0].d, q[1].d, q[2].d, q[3].d, a, b); else passed++;
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        send(mk(1'b1, 1'b1, 1'b0, 2'd0, {4{32'hE0E0_E0E0}}));
        idle(1);
        reset = 1'b1;
        bus.out_ready = 1'b0;
        idle(1);
        reset = 1'b0;
        total++; if ({bus.out_valid, bus.in_ready, bus.out_eop} !== 3'b010)
            $display("FAIL rstmid_ctl: valid/in_ready/eop got %b want 010", {bus.out_valid, bus.in_ready, bus.out_eop}); else passed++;
        q.delete();
        bus.out_ready = 1'b1;
        send(mk(1'b1, 1'b1, 1'b0, 2'd2, 128'hF00D_0001_F00D_0002_0000_0000_0000_0000));
        idle(4);
        total++; if (q.size() != 1) $display("FAIL rstmid_count: got %0d want 1", q.size()); else passed++;
        total++; if (q[0] !== '{d: 64'hF00D_0001_F00D_0002, sop: 1'b1, eop: 1'b1, err: 1'b0, empty: 1'b0})
            $display("FAIL rstmid_beat: got %h want f00d0001f00d0002 sop1 eop1 err0 empty0", q[0]); else passed++;
    endtask

    task automatic test_random();
        bit st = 1'b0;
        q.delete();
        exp_q.delete();
        rnd_en = 1'b1;
        for (int p = 0; p < 500; p++) begin
            int len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                logic eop = (k == len - 1);
                logic err = ($urandom_range(0, 9) == 0);
                logic [1:0] ew = 2'($urandom_range(0, 3));
                logic [1:0] ewe = eop ? ew : 2'd0;
                logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
                logic perr = st | err;
                logic one = ewe[1];
                st = !eop && perr;
                exp_q.push_back('{d: d[127:64], sop: k == 0, eop: eop && one, err: eop && one && perr, empty: eop && one && ewe[0]});
                if (!one) exp_q.push_back('{d: d[63:0], sop: 1'b0, eop: eop, err: eop && perr, empty: eop && ewe[0]});
                send(mk(eop, k == 0, err, ew, d));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        rnd_en = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() < exp_q.size(); i++) idle(1);
        total++; if (q.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= q.size() || q[i] !== exp_q[i]) $display("FAIL rand_beat%0d: got %h want %h", i, (i < q.size()) ? q[i] : ob_t'('0), exp_q[i]);
            else passed++;
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_three_beat();
        test_single_beat();
        test_error();
        test_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
